// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the two-digit seven-segment scanner.
package hex_scan_pkg;

  // Scan sequence: SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0.
  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } scan_state_t;

  // Segment patterns in gfedcba order (bit 0 = a), indexed by hex value.
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to gfedcba segment decoder.
module seg7_decode
  import hex_scan_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Table lookup; every nibble value has an entry.
  always_comb begin
    o_seg = SEG7_TABLE[i_nibble];
  end

endmodule

// File: rtl/hex_scan_mux.sv
// Two-digit time-multiplexed seven-segment scanner with a one-byte pending slot.
// A byte accepted over valid/ready is held in the pending slot and only moves
// to the display register at a frame boundary (BLANK1 -> SHOW0), so a digit
// never changes value mid-frame.
module hex_scan_mux
  import hex_scan_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50_000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter bit          LZ_BLANK     = 1'b1,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic [7:0] i_byte,
  output logic       o_ready,
  output logic [6:0] o_seg,
  output logic [1:0] o_digit_en,
  output logic       o_frame
);

  localparam int unsigned CNT_MAX = max_u(REFRESH_DIV, BLANK_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(REFRESH_DIV);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  scan_state_t      r_state;
  scan_state_t      w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;

  logic [7:0] r_disp;
  logic [7:0] w_disp_d;
  logic [7:0] r_pend;
  logic [7:0] w_pend_d;
  logic       r_pend_valid;
  logic       w_pend_valid_d;

  logic [6:0] r_seg;
  logic [6:0] w_seg_d;
  logic [1:0] r_digit_en;
  logic [1:0] w_digit_en_d;
  logic       r_frame;

  logic       w_last;
  logic       w_boundary;
  logic       w_commit;
  logic       w_ready;
  logic       w_accept;
  logic [3:0] w_nibble;
  logic [6:0] w_dec_seg;

  // Final cycle of the current state; <= guards against a zero load.
  assign w_last     = (r_cnt <= CNT_ONE);
  assign w_boundary = w_last && (r_state == BLANK1);
  // Commit only uses pending that was already held, so an accept in the
  // boundary cycle waits a full frame.
  assign w_commit   = w_boundary && r_pend_valid;

  // Ready is forced low while reset is held so nothing is taken in that cycle.
  assign w_ready  = !r_pend_valid && !i_reset;
  assign w_accept = i_valid && w_ready;

  // Scan sequencing: one down-counter reloaded on every state change.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt - CNT_ONE;
    if (w_last) begin
      unique case (r_state)
        SHOW0: begin
          w_state_d = BLANK0;
          w_cnt_d   = BLANK_LOAD;
        end
        BLANK0: begin
          w_state_d = SHOW1;
          w_cnt_d   = SHOW_LOAD;
        end
        SHOW1: begin
          w_state_d = BLANK1;
          w_cnt_d   = BLANK_LOAD;
        end
        default: begin
          w_state_d = SHOW0;
          w_cnt_d   = SHOW_LOAD;
        end
      endcase
    end
  end

  // Pending slot and display register next-state.
  always_comb begin
    w_disp_d       = r_disp;
    w_pend_d       = r_pend;
    w_pend_valid_d = r_pend_valid;
    if (w_commit) begin
      w_disp_d       = r_pend;
      w_pend_valid_d = 1'b0;
    end else if (w_accept) begin
      w_pend_d       = i_byte;
      w_pend_valid_d = 1'b1;
    end
  end

  // Nibble selected from next-state so registered outputs line up with r_state.
  assign w_nibble = (w_state_d == SHOW1) ? w_disp_d[7:4] : w_disp_d[3:0];

  seg7_decode u_seg7_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_dec_seg)
  );

  // Logical segment/enable values for the upcoming state.
  always_comb begin
    w_seg_d      = 7'h00;
    w_digit_en_d = 2'b00;
    unique case (w_state_d)
      SHOW0: begin
        w_seg_d      = w_dec_seg;
        w_digit_en_d = 2'b01;
      end
      SHOW1: begin
        w_seg_d      = w_dec_seg;
        w_digit_en_d = (LZ_BLANK && (w_disp_d[7:4] == 4'h0)) ? 2'b00 : 2'b10;
      end
      default: begin
        w_seg_d      = 7'h00;
        w_digit_en_d = 2'b00;
      end
    endcase
  end

  // State, data and output registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= BLANK1;
      r_cnt        <= BLANK_LOAD;
      r_disp       <= 8'h00;
      r_pend       <= 8'h00;
      r_pend_valid <= 1'b0;
      r_seg        <= 7'h00;
      r_digit_en   <= 2'b00;
      r_frame      <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_disp       <= w_disp_d;
      r_pend       <= w_pend_d;
      r_pend_valid <= w_pend_valid_d;
      r_seg        <= w_seg_d;
      r_digit_en   <= w_digit_en_d;
      r_frame      <= w_commit;
    end
  end

  // Pin polarity is applied last, after all logical rules.
  assign o_seg      = ACTIVE_LOW ? ~r_seg : r_seg;
  assign o_digit_en = ACTIVE_LOW ? ~r_digit_en : r_digit_en;
  assign o_frame    = r_frame;
  assign o_ready    = w_ready;

endmodule

// File: tb/tb_hex_scan_mux.sv
// Scoreboard bench for hex_scan_mux: three instances (LZ on, LZ off, active-low)
// share stimulus; accepted bytes are queued and a negedge monitor checks every
// cycle against a frame-position model.
module tb_hex_scan_mux;

  localparam int B = 2;
  localparam int R = 4;
  localparam int P = 2 * (R + B);

  localparam bit LZ [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit AL [3] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v   = 1'b0;
  logic [7:0] byte_i = 8'h00;

  logic       rdy [3];
  logic [6:0] seg [3];
  logic [1:0] en  [3];
  logic       frm [3];

  always #5 clk = ~clk;

  hex_scan_mux #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .LZ_BLANK(1'b1), .ACTIVE_LOW(1'b0)) u_dut_a (
    .i_clock(clk), .i_reset(rst), .i_valid(v), .i_byte(byte_i),
    .o_ready(rdy[0]), .o_seg(seg[0]), .o_digit_en(en[0]), .o_frame(frm[0])
  );
  hex_scan_mux #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .LZ_BLANK(1'b0), .ACTIVE_LOW(1'b0)) u_dut_b (
    .i_clock(clk), .i_reset(rst), .i_valid(v), .i_byte(byte_i),
    .o_ready(rdy[1]), .o_seg(seg[1]), .o_digit_en(en[1]), .o_frame(frm[1])
  );
  hex_scan_mux #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .LZ_BLANK(1'b1), .ACTIVE_LOW(1'b1)) u_dut_c (
    .i_clock(clk), .i_reset(rst), .i_valid(v), .i_byte(byte_i),
    .o_ready(rdy[2]), .o_seg(seg[2]), .o_digit_en(en[2]), .o_frame(frm[2])
  );

  logic [6:0] seg_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [7:0] b;
    int         t;
  } acc_t;

  acc_t acc_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   t        = -1;

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut=%0d cycle=%0d got=%0h expected=%0h", name, k, t, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard at expected commits and compares all outputs.
  bit         rst_seen = 1'b0;
  logic [7:0] disp     = 8'h00;
  always @(negedge clk) begin
    int         pos;
    bit         exp_frame;
    bit         exp_ready;
    logic [1:0] e_en;
    logic [6:0] e_seg;
    logic [3:0] nib;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        chk("ready_in_reset", k, int'(rdy[k]), 0);
        if (rst_seen) begin
          chk("en_in_reset", k, int'(en[k]), AL[k] ? 3 : 0);
          chk("seg_in_reset", k, int'(seg[k]), AL[k] ? 'h7F : 0);
          chk("frame_in_reset", k, int'(frm[k]), 0);
        end
      end
      rst_seen = 1'b1;
      t        = -1;
      disp     = 8'h00;
      acc_q.delete();
    end else begin
      rst_seen  = 1'b0;
      t++;
      exp_frame = 1'b0;
      pos       = (t >= B) ? (t - B) % P : -1;
      if (pos == 0 && acc_q.size() > 0 && acc_q[0].t < t - 1) begin
        exp_frame = 1'b1;
        disp      = acc_q[0].b;
        void'(acc_q.pop_front());
      end
      exp_ready = (acc_q.size() == 0);
      for (int k = 0; k < 3; k++) begin
        e_en  = 2'b00;
        e_seg = 7'h00;
        if (pos >= 0 && pos < R) begin
          nib   = disp[3:0];
          e_seg = seg_tab[nib];
          e_en  = 2'b01;
        end else if (pos >= R + B && pos < 2 * R + B) begin
          nib   = disp[7:4];
          e_seg = seg_tab[nib];
          e_en  = (LZ[k] && nib == 4'h0) ? 2'b00 : 2'b10;
        end
        if (AL[k]) begin
          e_en  = ~e_en;
          e_seg = ~e_seg;
        end
        chk("ready", k, int'(rdy[k]), int'(exp_ready));
        chk("frame", k, int'(frm[k]), int'(exp_frame));
        chk("digit_en", k, int'(en[k]), int'(e_en));
        chk("seg", k, int'(seg[k]), int'(e_seg));
      end
    end
  end

  // Ends the current cycle; records a transfer seen before the edge.
  task automatic cyc_end(output bit acc);
    @(negedge clk);
    #1;
    acc = v && rdy[0] && !rst;
    if (acc) acc_q.push_back('{b: byte_i, t: t});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    v = 1'b0;
    repeat (n) cyc_end(acc);
  endtask

  task automatic offer(input logic [7:0] b);
    bit acc;
    int n;
    v      = 1'b1;
    byte_i = b;
    acc    = 1'b0;
    n      = 0;
    while (!acc && n < 60) begin
      cyc_end(acc);
      n++;
    end
    v = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout byte=%02h got=no accept required=accept in 60 cycles", b);
    end
  endtask

  function automatic int cur_pos();
    return ((t + 1) - B) % P;
  endfunction

  task automatic wait_pos(input int p);
    bit acc;
    int n;
    n = 0;
    while (cur_pos() != p && n < 40) begin
      cyc_end(acc);
      n++;
    end
    if (cur_pos() != p) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_pos got=%0d required=%0d", cur_pos(), p);
    end
  endtask

  initial begin
    bit   acc;
    logic [7:0] rb;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(16);

    offer(8'hA5);
    idle(26);
    offer(8'h07);
    idle(26);

    offer(8'h12);
    offer(8'h34);
    idle(30);

    // Accept exactly in the BLANK1 -> SHOW0 transition cycle.
    idle(1);
    wait_pos(11);
    offer(8'h3C);
    idle(28);

    // Reset while a byte is pending in SHOW1.
    offer(8'h5A);
    offer(8'h66);
    wait_pos(7);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(30);
    offer(8'hC3);
    idle(26);

    // Randomized offers, each held until accepted.
    repeat (60) begin
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rb[7:4] = 4'h0;
      offer(rb);
      idle($urandom_range(0, 14));
    end
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
